// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 subset control sequencer.
package ctrl_pkg;

    localparam int unsigned OPC_W = 7;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned ALU_W = 2;
    localparam int unsigned RET_W = 32;

    // Major opcodes of the supported subset
    localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;

    // func3 values distinguishing the supported operations
    localparam logic [F3_W-1:0] F3_ADD  = 3'b000;
    localparam logic [F3_W-1:0] F3_AND  = 3'b111;
    localparam logic [F3_W-1:0] F3_OR   = 3'b110;
    localparam logic [F3_W-1:0] F3_WORD = 3'b010;
    localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
    localparam logic [F3_W-1:0] F3_BGE  = 3'b101;

    // ALU operation select driven to the datapath
    localparam logic [ALU_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALU_W-1:0] ALU_SUB = 2'b01;
    localparam logic [ALU_W-1:0] ALU_AND = 2'b10;
    localparam logic [ALU_W-1:0] ALU_OR  = 2'b11;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    // Decoded control set for one instruction
    typedef struct packed {
        logic             alu_src;
        logic [ALU_W-1:0] alu_ctrl;
        logic             mem_to_reg;
        logic             auipc;
        logic             beq;
        logic             bge;
        logic             is_load;
        logic             is_store;
    } ctrl_t;

    // Branches finish in EXEC without a writeback
    function automatic logic is_branch(input ctrl_t c);
        return c.beq | c.bge;
    endfunction

endpackage

// File: rtl/main_decoder.sv
// Combinational opcode/func3/func7 classifier producing the control set and a legal flag.
module main_decoder
    import ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    input  logic [F3_W-1:0]  func3_i,
    input  logic             func7_i,
    output ctrl_t            ctrl_o,
    output logic             legal_o
);

    // Map each supported encoding to its control set; anything else is illegal
    always_comb begin
        ctrl_o  = '0;
        legal_o = 1'b0;
        case (opcode_i)
            OP_R: begin
                case (func3_i)
                    F3_ADD: begin
                        legal_o         = 1'b1;
                        ctrl_o.alu_ctrl = func7_i ? ALU_SUB : ALU_ADD;
                    end
                    F3_AND: begin
                        legal_o         = 1'b1;
                        ctrl_o.alu_ctrl = ALU_AND;
                    end
                    F3_OR: begin
                        legal_o         = 1'b1;
                        ctrl_o.alu_ctrl = ALU_OR;
                    end
                    default: legal_o = 1'b0;
                endcase
            end
            OP_I: begin
                if (func3_i == F3_ADD) begin
                    legal_o         = 1'b1;
                    ctrl_o.alu_src  = 1'b1;
                    ctrl_o.alu_ctrl = ALU_ADD;
                end
            end
            OP_LOAD: begin
                if (func3_i == F3_WORD) begin
                    legal_o           = 1'b1;
                    ctrl_o.alu_src    = 1'b1;
                    ctrl_o.alu_ctrl   = ALU_ADD;
                    ctrl_o.mem_to_reg = 1'b1;
                    ctrl_o.is_load    = 1'b1;
                end
            end
            OP_STORE: begin
                if (func3_i == F3_WORD) begin
                    legal_o         = 1'b1;
                    ctrl_o.alu_src  = 1'b1;
                    ctrl_o.alu_ctrl = ALU_ADD;
                    ctrl_o.is_store = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (func3_i == F3_BEQ) begin
                    legal_o         = 1'b1;
                    ctrl_o.alu_ctrl = ALU_SUB;
                    ctrl_o.beq      = 1'b1;
                end else if (func3_i == F3_BGE) begin
                    legal_o         = 1'b1;
                    ctrl_o.alu_ctrl = ALU_SUB;
                    ctrl_o.bge      = 1'b1;
                end
            end
            OP_AUIPC: begin
                legal_o         = 1'b1;
                ctrl_o.alu_ctrl = ALU_ADD;
                ctrl_o.auipc    = 1'b1;
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 subset datapath.
// Strobes are decoded from the state register (ir_en also follows rom_rdy);
// the control set is registered at DECODE and held until the pc_en cycle.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] opcode,
    input  logic [F3_W-1:0]  func3,
    input  logic             func7,
    output logic             rom_req,
    input  logic             rom_rdy,
    output logic             ir_en,
    output logic             pc_en,
    output logic             MemtoReg,
    output logic             ALUSrc,
    output logic             RegWrite,
    output logic             beq,
    output logic             bge,
    output logic             auipc,
    output logic [ALU_W-1:0] ALUCtrl,
    output logic             mem_rd,
    output logic             mem_wr,
    input  logic             mem_ack,
    output logic             halt,
    output logic             illegal,
    output logic             bus_err,
    output logic [RET_W-1:0] retired
);

    // Last MEM wait cycle before the bus-error trap
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_e           state_q,   state_d;
    ctrl_t            ctrl_q,    ctrl_d;
    logic [TO_W-1:0]  to_cnt_q,  to_cnt_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic [RET_W-1:0] retired_q, retired_d;

    ctrl_t dec_ctrl;
    logic  dec_legal;

    main_decoder u_main_decoder (
        .opcode_i (opcode),
        .func3_i  (func3),
        .func7_i  (func7),
        .ctrl_o   (dec_ctrl),
        .legal_o  (dec_legal)
    );

    // State and bookkeeping registers; synchronous reset beats every other event
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            ctrl_q    <= '0;
            to_cnt_q  <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            to_cnt_q  <= to_cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            retired_q <= retired_d;
        end
    end

    // Next-state logic and per-state strobes
    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        to_cnt_d  = to_cnt_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        retired_d = retired_q;
        rom_req   = 1'b0;
        ir_en     = 1'b0;
        pc_en     = 1'b0;
        RegWrite  = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        halt      = 1'b0;

        case (state_q)
            ST_FETCH: begin
                // Held off while reset is asserted so every strobe reads 0
                rom_req = rst_n;
                ir_en   = rst_n & rom_rdy;
                if (rom_rdy) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    ctrl_d  = dec_ctrl;
                    state_d = ST_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
                end
            end
            ST_EXEC: begin
                if (is_branch(ctrl_q)) begin
                    pc_en   = 1'b1;
                    state_d = ST_FETCH;
                end else if (ctrl_q.is_load || ctrl_q.is_store) begin
                    to_cnt_d = '0;
                    state_d  = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                mem_rd = ctrl_q.is_load;
                mem_wr = ctrl_q.is_store;
                if (mem_ack) begin
                    // An ack on the last allowed cycle still completes the access
                    to_cnt_d = '0;
                    if (ctrl_q.is_store) begin
                        pc_en   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    to_cnt_d  = '0;
                    bus_err_d = 1'b1;
                    state_d   = ST_TRAP;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_WB: begin
                RegWrite = 1'b1;
                pc_en    = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_TRAP: begin
                halt = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Retirement closes the instruction and releases its control set
        if (pc_en) begin
            retired_d = retired_q + RET_W'(1);
            ctrl_d    = '0;
        end
        if (state_d == ST_TRAP) begin
            ctrl_d = '0;
        end
    end

    // Datapath controls straight from the held control set
    assign ALUSrc   = ctrl_q.alu_src;
    assign ALUCtrl  = ctrl_q.alu_ctrl;
    assign MemtoReg = ctrl_q.mem_to_reg;
    assign auipc    = ctrl_q.auipc;
    assign beq      = ctrl_q.beq;
    assign bge      = ctrl_q.bge;
    assign illegal  = illegal_q;
    assign bus_err  = bus_err_q;
    assign retired  = retired_q;

endmodule
